// File: rtl/lt_cmp_scheduler_pkg.sv
// Shared types and constants for the FP less-than comparator scheduler.
// Operands are FP 11/13 words with the two exception bits on top.
package lt_cmp_scheduler_pkg;

  localparam int FP_W     = 27;
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lt_cmp_scheduler_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
module rr_pick
  import lt_cmp_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Walk from the farthest offset back to ptr so the nearest hit overwrites.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      j = IW'((int'(ptr) + off) % N);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lt_cmp_scheduler.sv
// Shares one pipelined external FP less-than comparator among N_REQ requesters,
// tagging each issue so responses return in grant order with the requester id.
module lt_cmp_scheduler
  import lt_cmp_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = FP_W - 1,
  parameter int CMP_LAT = 3,
  localparam int IW = idx_w(N_REQ),
  localparam int OW = WIDTH + 1,
  localparam int CW = $clog2(CMP_LAT + 1) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*OW-1:0] req_a,
  input  logic [N_REQ*OW-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [OW-1:0]       cmp_a,
  output logic [OW-1:0]       cmp_b,
  input  logic                cmp_less,
  output logic                resp_valid,
  output logic [IW-1:0]       resp_id,
  output logic                resp_less,
  output logic [CW-1:0]       inflight
);

  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             issue;
  logic             retire;
  logic             unused_tag_id;
  tag_t             tag_q [CMP_LAT];

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign issue         = pick_any & rst_n & ~flush;
  assign req_ready     = issue ? pick_grant : '0;
  assign retire        = tag_q[CMP_LAT-1].valid;
  assign unused_tag_id = ^tag_q[CMP_LAT-1].id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      cmp_a  <= '0;
      cmp_b  <= '0;
    end else if (issue) begin
      rr_ptr <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IW'(1);
      cmp_a  <= req_a[pick_idx*OW +: OW];
      cmp_b  <= req_b[pick_idx*OW +: OW];
    end
  end

  // Tag stage CMP_LAT-1 lines up with the comparator result for the same issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CMP_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: issue, id: TAG_ID_W'(pick_idx)};
      for (int i = 1; i < CMP_LAT; i++)
        tag_q[i] <= '{valid: tag_q[i-1].valid & ~flush, id: tag_q[i-1].id};
    end
  end

  // Inflight counts live tags, so it retires on the edge that raises resp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_less  <= 1'b0;
      inflight   <= '0;
    end else begin
      resp_valid <= retire & ~flush;
      if (retire && !flush) begin
        resp_id   <= tag_q[CMP_LAT-1].id[IW-1:0];
        resp_less <= cmp_less;
      end
      if (flush)                inflight <= '0;
      else if (issue && !retire) inflight <= inflight + CW'(1);
      else if (!issue && retire) inflight <= inflight - CW'(1);
    end
  end

endmodule

// File: doc/lt_cmp_scheduler.md
LT_CMP_SCHEDULER -- requirements
Module: lt_cmp_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one FP less-than comparator.
REQ-002 Parameter WIDTH, default 26, MSB index of FP operand; operands are WIDTH+1 bits (FP 11/13 format, exception bits on top).
REQ-003 Parameter CMP_LAT, default 3, cycles from operands driven on cmp_a/cmp_b to matching cmp_less valid, ≥1.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous: discard all in-flight comparisons.
REQ-007 req_valid  input  N_REQ  per-requester request valid.
REQ-008 req_a  input  N_REQ*(WIDTH+1)  packed operand A; slot i at [i*(WIDTH+1) +: WIDTH+1].
REQ-009 req_b  input  N_REQ*(WIDTH+1)  packed operand B, same packing.
REQ-010 req_ready  output  N_REQ  one-hot or zero grant; transfer when req_valid[i] & req_ready[i].
REQ-011 cmp_a, cmp_b  output  WIDTH+1 each  registered operands to the external comparator.
REQ-012 cmp_less  input  1  comparator result, "A < B", CMP_LAT cycles after issue.
REQ-013 resp_valid  output  1  response strobe, one cycle.
REQ-014 resp_id  output  clog2(N_REQ) (min 1)  requester index of the response.
REQ-015 resp_less  output  1  comparator result for resp_id.
REQ-016 inflight  output  clog2(CMP_LAT+1)+1  number of issued comparisons not yet responded.

Function
REQ-017 At most one request granted per cycle; req_ready is combinational from req_valid and rr pointer, never asserted when flush=1.
REQ-018 Arbitration round-robin: search starts at rr_ptr, first valid index wins; after a grant to k, rr_ptr = (k+1) mod N_REQ; with no grant, rr_ptr holds.
REQ-019 On grant to k, cmp_a/cmp_b register req_a/req_b slot k at the next edge; cmp_a/cmp_b hold their value when no grant.
REQ-020 A tag pipeline of depth CMP_LAT carries {valid, id}; stage 0 loads {1,k} on grant, {0,x} otherwise.
REQ-021 resp_valid = tag valid at stage CMP_LAT-1 aligned with cmp_less; resp_id/resp_less sampled together; total request-accept to resp_valid latency = CMP_LAT+1 cycles.
REQ-022 Throughput one comparison per cycle, fully pipelined; responses cannot be back-pressured, requesters must accept resp_valid.
REQ-023 Responses leave in issue order; resp_id equals grant order exactly.
REQ-024 inflight increments on grant, decrements on resp_valid, unchanged when both occur same cycle; never exceeds CMP_LAT.
REQ-025 flush=1: all tag valids clear at next edge, inflight→0, no grant that cycle, no resp_valid for flushed entries; rr_ptr and cmp_a/cmp_b retain value.
REQ-026 A requester that drops req_valid without handshake is skipped; no request is lost once handshaken unless flushed or reset.
REQ-027 Single requester continuously valid receives a grant every cycle.

Reset
REQ-028 rst_n low asynchronously clears: tag valids, rr_ptr=0, inflight=0, resp_valid=0, resp_id=0, resp_less=0, cmp_a=cmp_b=0.
REQ-029 Reset mid-operation discards all in-flight comparisons; no resp_valid for them after release.
REQ-030 req_ready=0 while rst_n low; first grant possible on first edge after release.

Structure
REQ-031 Shared package holds FP operand width constant (27 bits) and the tag struct {valid, id}.
REQ-032 One sub-module, rr_pick: combinational round-robin picker (req vector, pointer → one-hot grant, index, any).
REQ-033 Comparator instantiated outside this block; when driving the active-high-reset comparator, top level passes ~rst_n.

Verification
REQ-034 N_REQ=4, CMP_LAT=3, only req 2 valid with A=1.0, B=2.0 -> grant cycle 0, resp_valid cycle 4, resp_id=2, resp_less=1.
REQ-035 All 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses same id order, one per cycle, inflight saturates at 3.
REQ-036 rr_ptr=1, req 0 and req 3 valid -> grant 3, then grant 0 next cycle.
REQ-037 Three requests issued, flush on cycle after third grant -> no resp_valid for those three, inflight=0 next cycle, new grant accepted one cycle later.
REQ-038 rst_n pulsed low with 2 comparisons in flight -> outputs zero immediately, no stale resp_valid after release.
REQ-039 A=B=-3.5 from req 1 -> resp_less=0; A=-3.5, B=0.0 -> resp_less=1.
